// File: rtl/universal_shift_register.sv
// universal_shift_register
//
// Parametrised WIDTH-bit register with hold, parallel load, serial shift
// right/left and an automatic multi-step shift engine.
//
// Optional feature macro: UNIVERSAL_SHIFT_REGISTER_ROTATE_EN
//   When defined, port Rot exists; Rot=1 turns every shift (manual or
//   automatic) into a rotate and the serial inputs are ignored.
//
// Ports:
//   Clk    in   clock, all state updates on rising edge
//   Rst_n  in   synchronous active-low reset
//   D      in   parallel load data
//   Mode   in   00 hold, 01 shift right, 10 shift left, 11 load
//   Ser_R  in   fill bit entering Q[WIDTH-1] on shift right
//   Ser_L  in   fill bit entering Q[0] on shift left
//   Start  in   request automatic shift of Amt steps in direction Mode
//   Amt    in   number of automatic shift steps
//   Rot    in   rotate select (ROTATE_EN builds only)
//   Q      out  register contents
//   Busy   out  automatic shift in progress (registered)
//   Done   out  one-cycle pulse after the last automatic shift (registered)

module universal_shift_register #(
  parameter int unsigned             WIDTH     = 4,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0,
  parameter int unsigned             CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       Mode,
  input  logic             Ser_R,
  input  logic             Ser_L,
  input  logic             Start,
  input  logic [CNT_W-1:0] Amt,
`ifdef UNIVERSAL_SHIFT_REGISTER_ROTATE_EN
  input  logic             Rot,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_left_q, dir_left_d;
  logic               done_q, done_d;

  logic               rot;
`ifdef UNIVERSAL_SHIFT_REGISTER_ROTATE_EN
  assign rot = Rot;
`else
  assign rot = 1'b0;
`endif

  // Shifted candidates; with rot set the bit leaving one end re-enters the other.
  logic [WIDTH-1:0] q_shr, q_shl;
  always_comb begin
    q_shr = {(rot ? q_q[0] : Ser_R), q_q[WIDTH-1:1]};
    q_shl = {q_q[WIDTH-2:0], (rot ? q_q[WIDTH-1] : Ser_L)};
  end

  logic auto_dir_mode;
  assign auto_dir_mode = (Mode == 2'b01) || (Mode == 2'b10);

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start && auto_dir_mode) begin
          // Q holds on the accepting edge; shifting starts on the next one.
          if (Amt != '0) begin
            dir_left_d = Mode[1];
            cnt_d      = Amt;
            state_d    = StRun;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          unique case (Mode)
            2'b00:   q_d = q_q;
            2'b01:   q_d = q_shr;
            2'b10:   q_d = q_shl;
            2'b11:   q_d = D;
            default: q_d = q_q;
          endcase
        end
      end
      StRun: begin
        q_d   = dir_left_q ? q_shl : q_shr;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      q_q        <= RESET_VAL;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      done_q     <= done_d;
    end
  end

  assign Q    = q_q;
  assign Busy = (state_q == StRun);
  assign Done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register (WIDTH=4, RESET_VAL=0): directed
// scenarios followed by random stimulus, all checked cycle by cycle against
// an integer reference model.

module tb_universal_shift_register;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic [WIDTH-1:0] D;
  logic [1:0]       Mode;
  logic             Ser_R, Ser_L, Start, Rot;
  logic [CNT_W-1:0] Amt;
  logic [WIDTH-1:0] Q;
  logic             Busy, Done;

  int checks = 0;
  int errors = 0;

  // Reference model state: register value, shifts still owed, direction.
  int m_q    = 0;
  int m_rem  = 0;
  int m_dir  = 0;   // 1 = right, 2 = left
  int m_done = 0;

  universal_shift_register #(
    .WIDTH    (WIDTH),
    .RESET_VAL(4'b0000)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .D    (D),
    .Mode (Mode),
    .Ser_R(Ser_R),
    .Ser_L(Ser_L),
    .Start(Start),
    .Amt  (Amt),
`ifdef UNIVERSAL_SHIFT_REGISTER_ROTATE_EN
    .Rot  (Rot),
`endif
    .Q    (Q),
    .Busy (Busy),
    .Done (Done)
  );

  always #5 Clk = ~Clk;

  function automatic int shift_val(int q, int dir, bit sr, bit sl, bit rot);
    int fill;
    if (dir == 1) begin
      fill = rot ? (q % 2) : int'(sr);
      return (q / 2) + fill * 8;
    end
    fill = rot ? (q / 8) : int'(sl);
    return ((q * 2) % 16) + fill;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs present now, clock once, compare.
  task automatic cycle();
    bit r;
    r = 1'b0;
`ifdef UNIVERSAL_SHIFT_REGISTER_ROTATE_EN
    r = Rot;
`endif
    m_done = 0;
    if (!Rst_n) begin
      m_q   = 0;
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_q = shift_val(m_q, m_dir, Ser_R, Ser_L, r);
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (Start && (Mode == 2'd1 || Mode == 2'd2)) begin
      if (Amt == 0) m_done = 1;
      else begin
        m_rem = int'(Amt);
        m_dir = int'(Mode);
      end
    end else begin
      case (Mode)
        2'd1: m_q = shift_val(m_q, 1, Ser_R, Ser_L, r);
        2'd2: m_q = shift_val(m_q, 2, Ser_R, Ser_L, r);
        2'd3: m_q = int'(D);
        default: ;
      endcase
    end
    @(posedge Clk);
    #1;
    check("q", 32'(Q), 32'(m_q));
    check("busy", 32'(Busy), 32'(m_rem > 0));
    check("done", 32'(Done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    Rst_n = 1'b1; Mode = 2'b00; Start = 1'b0; Amt = '0;
    D = '0; Ser_R = 1'b0; Ser_L = 1'b0; Rot = 1'b0;
  endtask

  task automatic load(logic [3:0] v);
    idle_inputs();
    Mode = 2'b11; D = v;
    cycle();
    Mode = 2'b00;
  endtask

  initial begin
    idle_inputs();
    Rst_n = 1'b0;
    cycle();

    // Reset from a loaded value, with load inputs active at the same time
    load(4'b1010);
    Rst_n = 1'b0; Mode = 2'b11; D = 4'b1111;
    cycle();
    check("reset_q", 32'(Q), 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);

    // Load then hold
    load(4'b1011);
    check("load_q", 32'(Q), 32'hB);
    repeat (3) cycle();
    check("hold_q", 32'(Q), 32'hB);

    // Manual shifts
    Mode = 2'b01; Ser_R = 1'b1;
    cycle();
    check("shr_q", 32'(Q), 32'hD);
    Mode = 2'b10; Ser_L = 1'b0;
    cycle();
    check("shl_q", 32'(Q), 32'hA);

    // Automatic left shift by 3, with a stray Start mid-run
    load(4'b0001);
    Mode = 2'b10; Start = 1'b1; Amt = 3'd3; Ser_L = 1'b0;
    cycle();
    check("auto_start_q", 32'(Q), 32'h1);
    Start = 1'b0; Mode = 2'b00;
    cycle();
    check("auto_s1_q", 32'(Q), 32'h2);
    Start = 1'b1; Mode = 2'b11; D = 4'hF; Amt = 3'd1;
    cycle();
    check("auto_s2_q", 32'(Q), 32'h4);
    Start = 1'b0; Mode = 2'b00;
    cycle();
    check("auto_s3_q", 32'(Q), 32'h8);
    check("auto_done", 32'(Done), 32'h1);
    cycle();
    check("auto_after_busy", 32'(Busy), 32'h0);
    check("auto_after_done", 32'(Done), 32'h0);

    // Amt = 0: immediate Done, no Busy
    Mode = 2'b01; Start = 1'b1; Amt = 3'd0;
    cycle();
    check("amt0_done", 32'(Done), 32'h1);
    check("amt0_q", 32'(Q), 32'h8);
    Start = 1'b0; Mode = 2'b00;
    cycle();

    // Amt = 6 right with Ser_R = 1, then back-to-back start in the Done cycle
    load(4'b0000);
    Mode = 2'b01; Start = 1'b1; Amt = 3'd6; Ser_R = 1'b1;
    cycle();
    Start = 1'b0; Mode = 2'b00;
    repeat (6) cycle();
    check("amt6_q", 32'(Q), 32'hF);
    check("amt6_done", 32'(Done), 32'h1);
    Mode = 2'b10; Start = 1'b1; Amt = 3'd2; Ser_L = 1'b0;
    cycle();
    Start = 1'b0; Mode = 2'b00;
    repeat (2) cycle();
    check("b2b_q", 32'(Q), 32'hC);

    // Reset after one shift of a 3-step run
    load(4'b0001);
    Mode = 2'b10; Start = 1'b1; Amt = 3'd3;
    cycle();
    Start = 1'b0; Mode = 2'b00;
    cycle();
    Rst_n = 1'b0;
    cycle();
    Rst_n = 1'b1;
    cycle();
    check("abort_q", 32'(Q), 32'h0);
    check("abort_done", 32'(Done), 32'h0);

`ifdef UNIVERSAL_SHIFT_REGISTER_ROTATE_EN
    load(4'b1001);
    Mode = 2'b01; Rot = 1'b1; Ser_R = 1'b0;
    cycle();
    check("rot_r_q", 32'(Q), 32'hC);
    Mode = 2'b10; Start = 1'b1; Amt = 3'd4; Ser_L = 1'b0;
    cycle();
    Start = 1'b0; Mode = 2'b00;
    repeat (4) cycle();
    check("rot_auto_q", 32'(Q), 32'hC);
    Rot = 1'b0;
`endif

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      Rst_n = ($urandom_range(0, 39) != 0);
      Mode  = 2'($urandom_range(0, 3));
      D     = 4'($urandom);
      Ser_R = 1'($urandom);
      Ser_L = 1'($urandom);
      Start = ($urandom_range(0, 3) == 0);
      Amt   = 3'($urandom_range(0, 7));
`ifdef UNIVERSAL_SHIFT_REGISTER_ROTATE_EN
      Rot   = 1'($urandom);
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
